store_burst_scheduler: RTL and testbench

Controller in front of the store datapath: accepts one vector-store memory request (start address, byte count) and sequences it into AXI INCR write bursts. For each burst it issues the AXI AW beat and the matching per-burst control record that the sequential store stage consumes. It also bounds the number of outstanding bursts, collects B responses, and reports completion with an error flag. It sits between the VLSU address/request front end and the store unit, whose W-channel output it paces through the control records.

---
 rtl/store_burst_scheduler.sv | 175 +++++++++++++++++
 tb/tb_store_burst_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_burst_scheduler.sv
// Splits one vector-store request into 4KB-safe AXI INCR bursts, pairing each AW beat
// with a control record for the store stage, and tracks outstanding B responses.
module store_burst_scheduler #(
  parameter int AxiDataWidth   = 64,
  parameter int AxiAddrWidth   = 32,
  parameter int AxiIdWidth     = 4,
  parameter int LenWidth       = 32,
  parameter int MaxOutstanding = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [AxiAddrWidth-1:0]            req_addr_i,
  input  logic [LenWidth-1:0]                req_bytes_i,
  input  logic [AxiIdWidth-1:0]              req_id_i,
  output logic                               aw_valid_o,
  input  logic                               aw_ready_i,
  output logic [AxiAddrWidth-1:0]            aw_addr_o,
  output logic [7:0]                         aw_len_o,
  output logic [2:0]                         aw_size_o,
  output logic [1:0]                         aw_burst_o,
  output logic [AxiIdWidth-1:0]              aw_id_o,
  output logic                               txn_valid_o,
  input  logic                               txn_ready_i,
  output logic [8:0]                         txn_beats_o,
  output logic [$clog2(AxiDataWidth/8)-1:0]  txn_first_off_o,
  output logic [$clog2(AxiDataWidth/8):0]    txn_last_bytes_o,
  input  logic                               b_valid_i,
  output logic                               b_ready_o,
  input  logic [1:0]                         b_resp_i,
  output logic                               done_valid_o,
  input  logic                               done_ready_i,
  output logic                               done_err_o
);

  localparam int BeatBytes = AxiDataWidth / 8;
  localparam int OffW      = $clog2(BeatBytes);
  localparam int CntW      = $clog2(MaxOutstanding + 1);
  localparam int CW        = (LenWidth > 17) ? LenWidth : 17;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [AxiAddrWidth-1:0] cur_addr;
  logic [LenWidth-1:0]     rem_bytes;
  logic [AxiIdWidth-1:0]   id;
  logic [CntW-1:0]         outstanding, cnt_nxt;
  logic                    aw_sent, txn_sent, err;

  logic [CW-1:0] off_w, to_4k, max_b, rem_w, bb, end_w, end_m1, beats_w;
  logic [OffW:0] last_bytes;
  logic          is_issue, req_hs, aw_hs, txn_hs, b_hs, burst_cmp, last_burst;

  function automatic logic [CW-1:0] min_u(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Burst geometry: bounded by remaining bytes, the 4KB page and 256 beats
  always_comb begin
    off_w      = CW'(cur_addr[OffW-1:0]);
    to_4k      = CW'(4096) - CW'(cur_addr[11:0]);
    max_b      = CW'(256 * BeatBytes) - off_w;
    rem_w      = CW'(rem_bytes);
    bb         = min_u(rem_w, min_u(to_4k, max_b));
    end_w      = off_w + bb;
    end_m1     = end_w - CW'(1);
    beats_w    = (end_w + CW'(BeatBytes - 1)) >> OffW;
    last_bytes = {1'b0, end_m1[OffW-1:0]} + 1'b1;
  end

  assign is_issue    = (state == ISSUE);
  assign aw_valid_o  = is_issue && !aw_sent && (outstanding < MaxCnt);
  assign txn_valid_o = is_issue && !txn_sent;
  assign b_ready_o   = (outstanding != '0);

  assign req_hs     = req_valid_i && req_ready_o;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign txn_hs     = txn_valid_o && txn_ready_i;
  assign b_hs       = b_valid_i && b_ready_o;
  assign burst_cmp  = is_issue && (aw_sent || aw_hs) && (txn_sent || txn_hs);
  assign last_burst = (rem_w == bb);

  // Payloads are zeroed outside ISSUE; within a burst they only depend on held registers
  assign aw_addr_o        = is_issue ? cur_addr : '0;
  assign aw_len_o         = is_issue ? 8'(beats_w - CW'(1)) : '0;
  assign aw_size_o        = 3'(OffW);
  assign aw_burst_o       = 2'b01;
  assign aw_id_o          = is_issue ? id : '0;
  assign txn_beats_o      = is_issue ? 9'(beats_w) : '0;
  assign txn_first_off_o  = is_issue ? cur_addr[OffW-1:0] : '0;
  assign txn_last_bytes_o = is_issue ? last_bytes : '0;
  assign done_err_o       = (state == DONE) && err;

  always_comb begin
    cnt_nxt = outstanding;
    if (aw_hs && !b_hs)
      cnt_nxt = outstanding + 1'b1;
    else if (!aw_hs && b_hs)
      cnt_nxt = outstanding - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    done_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (burst_cmp && last_burst)
          state_nxt = (cnt_nxt == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (cnt_nxt == '0)
          state_nxt = DONE;
      end
      DONE: begin
        done_valid_o = 1'b1;
        if (done_ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      aw_sent     <= 1'b0;
      txn_sent    <= 1'b0;
      err         <= 1'b0;
    end else begin
      outstanding <= cnt_nxt;
      if (b_hs)
        err <= err | b_resp_i[1];
      if (req_hs) begin
        err      <= 1'b0;
        aw_sent  <= 1'b0;
        txn_sent <= 1'b0;
      end else if (burst_cmp) begin
        aw_sent  <= 1'b0;
        txn_sent <= 1'b0;
      end else begin
        if (aw_hs)
          aw_sent <= 1'b1;
        if (txn_hs)
          txn_sent <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      cur_addr  <= req_addr_i;
      rem_bytes <= req_bytes_i;
      id        <= req_id_i;
    end else if (burst_cmp) begin
      cur_addr  <= cur_addr + AxiAddrWidth'(bb);
      rem_bytes <= rem_bytes - LenWidth'(bb);
    end
  end

endmodule

// File: tb/tb_store_burst_scheduler.sv
// Scoreboard bench for store_burst_scheduler: directed requests push expected AW, txn and
// done records; a negedge monitor pops and compares them on each handshake.
module tb_store_burst_scheduler;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_bytes;
  logic [3:0]  req_id;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_id;
  logic        txn_valid, txn_ready;
  logic [8:0]  txn_beats;
  logic [2:0]  txn_first_off;
  logic [3:0]  txn_last_bytes;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        done_valid, done_ready, done_err;

  store_burst_scheduler #(
    .AxiDataWidth(64), .AxiAddrWidth(32), .AxiIdWidth(4), .LenWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_bytes_i(req_bytes), .req_id_i(req_id),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_len_o(aw_len),
    .aw_size_o(aw_size), .aw_burst_o(aw_burst), .aw_id_o(aw_id),
    .txn_valid_o(txn_valid), .txn_ready_i(txn_ready), .txn_beats_o(txn_beats),
    .txn_first_off_o(txn_first_off), .txn_last_bytes_o(txn_last_bytes),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_err_o(done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } aw_t;

  typedef struct packed {
    logic [8:0] beats;
    logic [2:0] off;
    logic [3:0] last;
  } txn_t;

  aw_t  aw_q[$];
  txn_t txn_q[$];
  logic done_q[$];

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0;
  int b_cnt = 0;
  int done_cnt = 0;
  int drop = 0;
  logic b_auto = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i);
    aw_t e;
    e.addr = a; e.len = l; e.id = i;
    aw_q.push_back(e);
  endtask

  task automatic push_txn(input logic [8:0] b, input logic [2:0] o, input logic [3:0] l);
    txn_t e;
    e.beats = b; e.off = o; e.last = l;
    txn_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the handshake edge
  task automatic do_req(input logic [31:0] a, input logic [31:0] n, input logic [3:0] i);
    bit ok = 0;
    req_valid = 1'b1; req_addr = a; req_bytes = n; req_id = i;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    step();
    req_valid = 1'b0; req_addr = '0; req_bytes = '0; req_id = '0;
    if (!ok) fail_now("req_handshake");
  endtask

  task automatic send_b(input logic [1:0] r);
    bit ok = 0;
    b_valid = 1'b1; b_resp = r;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_ready) begin ok = 1; break; end
    end
    step();
    b_valid = 1'b0; b_resp = 2'b00;
    if (!ok) fail_now("b_handshake");
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    if (done_cnt < target) fail_now("done_handshake");
    step();
  endtask

  task automatic wait_aw(input int target);
    for (int k = 0; k < 200; k++) begin
      if (aw_cnt >= target) break;
      @(negedge clk);
    end
    if (aw_cnt < target) fail_now("aw_count");
  endtask

  // Monitor: handshakes seen at a falling edge complete on the next rising edge
  initial begin
    aw_t  ea;
    txn_t et;
    logic ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (aw_valid && aw_ready) begin
          aw_cnt++;
          if (aw_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got AW addr 0x%0h, expected no AW", aw_addr);
          end else begin
            ea = aw_q.pop_front();
            check("aw_addr", 64'(aw_addr), 64'(ea.addr));
            check("aw_len", 64'(aw_len), 64'(ea.len));
            check("aw_id", 64'(aw_id), 64'(ea.id));
            check("aw_size", 64'(aw_size), 64'd3);
            check("aw_burst", 64'(aw_burst), 64'd1);
          end
        end
        if (txn_valid && txn_ready) begin
          if (txn_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL txn_unexpected: got txn beats %0d, expected no txn", txn_beats);
          end else begin
            et = txn_q.pop_front();
            check("txn_beats", 64'(txn_beats), 64'(et.beats));
            check("txn_first_off", 64'(txn_first_off), 64'(et.off));
            check("txn_last_bytes", 64'(txn_last_bytes), 64'(et.last));
          end
        end
        if (b_valid && b_ready) b_cnt++;
        if (done_valid && done_ready) begin
          done_cnt++;
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done err %0d, expected no done", done_err);
          end else begin
            ed = done_q.pop_front();
            check("done_err", 64'(done_err), 64'(ed));
          end
        end
      end
    end
  end

  // Automatic B responder: one OKAY per outstanding AW
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (b_auto) begin
        b_valid = ((aw_cnt - b_cnt - drop) > 0);
        b_resp  = 2'b00;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_bytes = '0; req_id = '0;
    aw_ready = 1'b0; txn_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00; done_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_aw_valid", 64'(aw_valid), 64'd0);
    check("rst_txn_valid", 64'(txn_valid), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_done_err", 64'(done_err), 64'd0);
    check("rst_aw_addr", 64'(aw_addr), 64'd0);
    check("rst_aw_len", 64'(aw_len), 64'd0);
    check("rst_aw_size", 64'(aw_size), 64'd3);
    check("rst_aw_burst", 64'(aw_burst), 64'd1);
    check("rst_txn_beats", 64'(txn_beats), 64'd0);
    check("rst_txn_last", 64'(txn_last_bytes), 64'd0);
    step();
    rst = 1'b0;

    // Unaligned short request: 4+10 bytes span two 8-byte beats
    b_auto = 1'b1; aw_ready = 1'b1; txn_ready = 1'b1;
    push_aw(32'h1004, 8'd1, 4'd3); push_txn(9'd2, 3'd4, 4'd6); done_q.push_back(1'b0);
    do_req(32'h1004, 32'd10, 4'd3);
    wait_done(1);

    // 4KB page crossing
    push_aw(32'h0FF8, 8'd0, 4'd2); push_txn(9'd1, 3'd0, 4'd8);
    push_aw(32'h1000, 8'd0, 4'd2); push_txn(9'd1, 3'd0, 4'd8);
    done_q.push_back(1'b0);
    do_req(32'h0FF8, 32'd16, 4'd2);
    wait_done(2);

    // 256-beat length cap
    push_aw(32'h0000, 8'd255, 4'd4); push_txn(9'd256, 3'd0, 4'd8);
    push_aw(32'h0800, 8'd255, 4'd4); push_txn(9'd256, 3'd0, 4'd8);
    done_q.push_back(1'b0);
    do_req(32'h0, 32'd4096, 4'd4);
    wait_done(3);

    // Decoupled channels: txn stalled three cycles while AW proceeds
    txn_ready = 1'b0;
    push_aw(32'h3FF8, 8'd0, 4'd7); push_txn(9'd1, 3'd0, 4'd8);
    push_aw(32'h4000, 8'd0, 4'd7); push_txn(9'd1, 3'd0, 4'd8);
    done_q.push_back(1'b0);
    do_req(32'h3FF8, 32'd16, 4'd7);
    @(negedge clk);
    check("dec_aw_valid_first", 64'(aw_valid), 64'd1);
    check("dec_txn_valid_first", 64'(txn_valid), 64'd1);
    @(negedge clk);
    check("dec_aw_valid_held1", 64'(aw_valid), 64'd0);
    @(negedge clk);
    check("dec_aw_valid_held2", 64'(aw_valid), 64'd0);
    check("dec_aw_addr_held", 64'(aw_addr), 64'h3FF8);
    step();
    txn_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("dec_aw_valid_next", 64'(aw_valid), 64'd1);
    check("dec_aw_addr_next", 64'(aw_addr), 64'h4000);
    step();
    wait_done(4);

    // Outstanding limit of 2 with manual B responses, one SLVERR
    b_auto = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_aw(32'(k * 2048), 8'd255, 4'd1);
      push_txn(9'd256, 3'd0, 4'd8);
    end
    done_q.push_back(1'b1);
    begin
      int base;
      base = aw_cnt;
      do_req(32'h0, 32'd8192, 4'd1);
      wait_aw(base + 2);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("lim_aw_valid_stall", 64'(aw_valid), 64'd0);
      end
      check("lim_aw_count_stall", 64'(aw_cnt - base), 64'd2);
      step();
      send_b(2'b00);
      @(negedge clk);
      check("lim_aw_valid_release", 64'(aw_valid), 64'd1);
      check("lim_aw_addr_release", 64'(aw_addr), 64'h1000);
      step();
      send_b(2'b10);
      send_b(2'b00);
      send_b(2'b00);
      wait_done(5);
    end

    // Reset in ISSUE after the first of four bursts
    aw_ready = 1'b0; txn_ready = 1'b0;
    push_aw(32'h0, 8'd255, 4'd6); push_txn(9'd256, 3'd0, 4'd8);
    do_req(32'h0, 32'd8192, 4'd6);
    aw_ready = 1'b1; txn_ready = 1'b1;
    step();
    aw_ready = 1'b0; txn_ready = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_aw_valid", 64'(aw_valid), 64'd0);
    check("mid_rst_txn_valid", 64'(txn_valid), 64'd0);
    check("mid_rst_b_ready", 64'(b_ready), 64'd0);
    check("mid_rst_done_valid", 64'(done_valid), 64'd0);
    step();
    rst = 1'b0;
    b_valid = 1'b1; b_resp = 2'b11;
    @(negedge clk);
    check("stray_b_ready", 64'(b_ready), 64'd0);
    step();
    b_valid = 1'b0; b_resp = 2'b00;
    drop = aw_cnt - b_cnt;
    b_auto = 1'b1; aw_ready = 1'b1; txn_ready = 1'b1;
    push_aw(32'h2000, 8'd0, 4'd5); push_txn(9'd1, 3'd0, 4'd8); done_q.push_back(1'b0);
    do_req(32'h2000, 32'd8, 4'd5);
    wait_done(6);

    check("left_aw_q", 64'(aw_q.size()), 64'd0);
    check("left_txn_q", 64'(txn_q.size()), 64'd0);
    check("left_done_q", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
